// File: rtl/mdu_e.sv
// Iterative RV32M multiply/divide unit for the execute stage (shift-add multiply, restoring divide).
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier; divides stay iterative.
module mdu_e #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  // Handshake: start_i is a level held by the E stage; it is accepted in IDLE when flush_i is low,
  // busy_o stalls the pipeline from the start cycle through BUSY, and done_o marks the single
  // cycle in which result_o is valid and the pipeline is released.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic             neg_q_q, neg_r_q, bzero_q;
  logic [XLEN-1:0]  acc_q, lo_q, b_q, result_q;
  logic             accept, last_iter, fast_accept;

  // Operand signedness decoded from funct3 at accept time only.
  logic            a_sgn_en, b_sgn_en, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    if (funct3_i[2]) begin
      a_sgn_en = ~funct3_i[0];
      b_sgn_en = ~funct3_i[0];
    end else begin
      a_sgn_en = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
      b_sgn_en = (funct3_i[1:0] == 2'b01);
    end
    sa    = a_sgn_en & op_a_i[XLEN-1];
    sb    = b_sgn_en & op_b_i[XLEN-1];
    mag_a = sa ? -op_a_i : op_a_i;
    mag_b = sb ? -op_b_i : op_b_i;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic        [XLEN-1:0]   fast_res;
  assign fast_a      = {{XLEN{sa}}, op_a_i};
  assign fast_b      = {{XLEN{sb}}, op_b_i};
  assign fast_p      = fast_a * fast_b;
  assign fast_res    = (funct3_i[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  assign fast_accept = ~funct3_i[2];
`else
  assign fast_accept = 1'b0;
`endif

  // One iteration step; acc_q holds product-high / partial remainder, lo_q multiplier / quotient.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_rem_n, div_q_n;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_prod, mul_signed;
  logic [XLEN-1:0]   mul_res, q_fin, r_fin, final_res;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_n   = mul_sum[XLEN:1];
    mul_lo_n   = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift  = {acc_q, lo_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, b_q};
    // With a zero divisor no quotient bit is set, so the remainder ends as |op_a|.
    div_ok     = ~div_diff[XLEN] & ~bzero_q;
    div_rem_n  = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_q_n    = {lo_q[XLEN-2:0], div_ok};
    mul_prod   = {mul_hi_n, mul_lo_n};
    mul_signed = neg_q_q ? -mul_prod : mul_prod;
    mul_res    = (f3_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    q_fin      = bzero_q ? '1 : (neg_q_q ? -div_q_n : div_q_n);
    r_fin      = neg_r_q ? -div_rem_n : div_rem_n;
    final_res  = f3_q[2] ? (f3_q[1] ? r_fin : q_fin) : mul_res;
  end

  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i && !flush_i) begin
        accept  = 1'b1;
        busy_o  = 1'b1;
        state_d = fast_accept ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        busy_o = 1'b1;
        if (flush_i)        state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst_i) busy_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q    <= funct3_i;
        neg_q_q <= sa ^ sb;
        neg_r_q <= sa;
        bzero_q <= (op_b_i == '0);
        acc_q   <= '0;
        lo_q    <= mag_a;
        b_q     <= mag_b;
        cnt_q   <= '0;
`ifdef MDU_FAST_MUL_EN
        if (fast_accept) result_q <= fast_res;
`endif
      end else if (state_q == S_BUSY && !flush_i) begin
        acc_q <= f3_q[2] ? div_rem_n : mul_hi_n;
        lo_q  <= f3_q[2] ? div_q_n : mul_lo_n;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_iter) result_q <= final_res;
      end
    end
  end

  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed corner cases, flush/reset aborts, back-to-back and random ops.
module tb_mdu_e;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  mdu_e dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from RV32M arithmetic on 64-bit integers.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa_l, sb_l, ua_l, ub_l;
    logic [63:0] p;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua_l = longint'({32'b0, a});
    ub_l = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa_l * sb_l; return p[31:0];  end
      3'd1: begin p = sa_l * sb_l; return p[63:32]; end
      3'd2: begin p = sa_l * ub_l; return p[63:32]; end
      3'd3: begin p = ua_l * ub_l; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa_l / sb_l; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa_l % sb_l; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drives one instruction from a negedge and returns in its done cycle (start_i left high).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp_res, got;
    int          exp_lat, lat;
    bit          busy_ok;
    logic        busy_at_done;
    exp_res = ref_mdu(f3, a, b);
    exp_lat = 33;
`ifdef MDU_FAST_MUL_EN
    if (!f3[2]) exp_lat = 1;
`endif
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL %s start_busy: got %b want 1", name, busy_o);
    end
    lat = 0; busy_ok = 1'b1; got = 'x; busy_at_done = 1'bx;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk_i);
      if (i == 3) begin
        op_a_i = $urandom; op_b_i = $urandom; funct3_i = 3'($urandom_range(0, 7));
      end
      if (done_o === 1'b1) begin
        lat = i; got = result_o; busy_at_done = busy_o;
      end else if (busy_o !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (got !== exp_res) begin
      errors++; $display("FAIL %s result: got %h want %h (f3=%0d a=%h b=%h)", name, got, exp_res, f3, a, b);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy_at_done);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s busy_hold: busy dropped before done, want continuous 1", name);
    end
    last_exp = exp_res;
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL %s idle: got busy=%b done=%b want 0/0", name, busy_o, done_o);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    run_op(f3, a, b, name);
    idle_cycle(name);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd100; op_b_i = 32'd7;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++;
    if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_cycle("after_reset");
  endtask

  task automatic test_directed;
    do_op(3'd4, 32'd100, 32'd7, "div_100_7");
    do_op(3'd6, 32'd100, 32'd7, "rem_100_7");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, "divu_big");
    do_op(3'd5, 32'h1234, 32'd0, "divu_by0");
    do_op(3'd7, 32'h1234, 32'd0, "remu_by0");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0, "rem_neg_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
  endtask

  task automatic test_mul_corners;
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_m1");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
  endtask

  task automatic test_back_to_back;
    run_op(3'd0, 32'd3, 32'd4, "b2b_first");
    run_op(3'd0, 32'd5, 32'd6, "b2b_second");
    run_op(3'd5, 32'd50, 32'd8, "b2b_third");
    idle_cycle("b2b_end");
  endtask

  task automatic test_flush;
    // Flush in IDLE blocks acceptance.
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd77; op_b_i = 32'd5;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b want 0", busy_o); end
    idle_cycle("flush_idle");
    // Flush in BUSY aborts without done and keeps the old result.
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd3;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy_abort: got busy=%b done=%b want 0/0", busy_o, done_o);
    end
    checks++;
    if (result_o !== last_exp) begin
      errors++; $display("FAIL flush_result_hold: got %h want %h", result_o, last_exp);
    end
    run_op(3'd4, 32'd9, 32'd3, "flush_restart");
    // Flush during DONE: the done cycle is not suppressed.
    flush_i = 1'b1;
    #1;
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL flush_done_pulse: got %b want 1", done_o); end
    idle_cycle("flush_done");
    checks++;
    if (result_o !== last_exp) begin
      errors++; $display("FAIL flush_done_hold: got %h want %h", result_o, last_exp);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'd3; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h1234_5678;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 1'b0 || result_o !== 32'd0) begin
      errors++; $display("FAIL rstmid_outputs: got done=%b result=%h want 0/0", done_o, result_o);
    end
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'd0) begin
        errors++; $display("FAIL rstmid_after: got done=%b busy=%b result=%h want 0/0/0", done_o, busy_o, result_o);
      end
    end
    last_exp = 32'd0;
    do_op(3'd3, 32'd7, 32'd6, "rstmid_recover");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 1) == 0) do_op(f3, a, b, "rand");
      else                           run_op(f3, a, b, "rand_b2b");
    end
    idle_cycle("rand_end");
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op_a_i = '0; op_b_i = '0;
    test_reset();
    test_directed();
    test_mul_corners();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
